// File: rtl/dem_gpg_display.sv
// rtl/dem_gpg_display.sv - eight-digit multiplexed 7-segment time display with lap freeze and field blink
//
// Purpose: scans eight active-low digits showing gio:phut:giay:ptgiay, each
// field as two decimal digits (idx0/1 ptgiay, idx2/3 giay, idx4/5 phut,
// idx6/7 gio; even idx = units, odd idx = tens). A lap pulse toggles a
// freeze that holds a snapshot of the time fields. While blink is high the
// field chosen by gt_mod is blanked. All state changes on the falling edge
// of ckht.
//
// Ports:
//   ckht        in   system clock (falling-edge active)
//   rst         in   synchronous active-high reset
//   ena_scan    in   one-cycle tick, advance to next digit
//   ena_blink   in   one-cycle tick, toggle blink phase
//   lap         in   one-cycle pulse, toggle display freeze
//   gt_mod[1:0] in   field being set: 00 none, 01 giay, 10 phut, 11 gio
//   gio, phut, giay, ptgiay [6:0] in  binary time fields
//   an[7:0]     out  active-low digit enables (registered)
//   seg[6:0]    out  active-low segments {g,f,e,d,c,b,a} (registered)
//   dp          out  active-low decimal point (registered)

module dem_gpg_display (
  input  logic       ckht,
  input  logic       rst,
  input  logic       ena_scan,
  input  logic       ena_blink,
  input  logic       lap,
  input  logic [1:0] gt_mod,
  input  logic [6:0] gio,
  input  logic [6:0] phut,
  input  logic [6:0] giay,
  input  logic [6:0] ptgiay,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  logic [2:0] r_idx;
  logic       r_blink;
  logic       r_freeze;
  logic [6:0] r_gio;
  logic [6:0] r_phut;
  logic [6:0] r_giay;
  logic [6:0] r_ptgiay;
  logic [7:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;

  logic [6:0] w_val;
  logic [3:0] w_tens;
  logic [3:0] w_units;
  logic [3:0] w_digit;
  logic       w_blank;
  logic [6:0] w_seg;
  logic       w_dp_on;
  logic [7:0] w_an;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  always_comb begin
    // idx[2:1] picks the field; idx[0] picks tens over units
    case (r_idx[2:1])
      2'd0:    w_val = r_ptgiay;
      2'd1:    w_val = r_giay;
      2'd2:    w_val = r_phut;
      default: w_val = r_gio;
    endcase
    w_tens  = 4'(w_val / 7'd10);
    w_units = 4'(w_val % 7'd10);
    w_digit = r_idx[0] ? w_tens : w_units;
    // gt_mod encodings line up with idx[2:1] for giay/phut/gio; 00 never blanks
    w_blank = r_blink && (gt_mod != 2'd0) && (r_idx[2:1] == gt_mod);
    // values above 99 cannot be shown in two digits, so show a dash
    w_seg   = (w_val > 7'd99) ? 7'h3F : seg_code(w_digit);
    // decimal point separates fields: on the units digit of giay, phut, gio
    w_dp_on = !r_idx[0] && (r_idx != 3'd0);
    w_an    = ~(8'd1 << r_idx);
  end

  always_ff @(negedge ckht) begin
    if (rst) begin
      r_idx    <= 3'd0;
      r_blink  <= 1'b0;
      r_freeze <= 1'b0;
      r_gio    <= 7'd0;
      r_phut   <= 7'd0;
      r_giay   <= 7'd0;
      r_ptgiay <= 7'd0;
      r_an     <= 8'hFF;
      r_seg    <= 7'h7F;
      r_dp     <= 1'b1;
    end else begin
      if (ena_scan)  r_idx   <= r_idx + 3'd1;
      if (ena_blink) r_blink <= ~r_blink;
      if (lap)       r_freeze <= ~r_freeze;
      // the load decision uses the old freeze, so the lap edge that freezes
      // still captures that cycle's time
      if (!r_freeze) begin
        r_gio    <= gio;
        r_phut   <= phut;
        r_giay   <= giay;
        r_ptgiay <= ptgiay;
      end
      if (w_blank) begin
        r_an  <= 8'hFF;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= w_an;
        r_seg <= w_seg;
        r_dp  <= ~w_dp_on;
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
